hba_master_queued: RTL and testbench

//  Queued HBA bus master. Buffers app-side read/write commands in a CMD_DEPTH-entry FIFO.

---
 rtl/hba_master_queued_pkg.sv | 16 +
 rtl/hba_cmd_fifo.sv | 51 +++++
 rtl/hba_master_queued.sv | 142 ++++++++++++++
 tb/tb_hba_master_queued.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hba_master_queued_pkg.sv
// Shared types and helpers for the queued HBA bus master.
package hba_master_queued_pkg;

  // Master FSM states; encoding 2'b11 is unused and recovers to ST_IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_e;

  // Watchdog counter width; a disabled watchdog still keeps one bit
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/hba_cmd_fifo.sv
// Synchronous command FIFO; an entry becomes readable the cycle after it is written.
module hba_cmd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign o_count    = r_wr_ptr - r_rd_ptr;
  assign o_full     = (o_count == (AW+1)'(DEPTH));
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_do_push  = i_push && !o_full;
  assign w_do_pop   = i_pop && !o_empty;
  assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array; contents need no reset since pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end
  end

  // Pointer update; reset flushes the queue
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/hba_master_queued.sv
// Queued HBA bus master: buffers app commands and issues them one at a time on the bus.
module hba_master_queued
  import hba_master_queued_pkg::*;
#(
  parameter int unsigned DBUS_WIDTH        = 8,
  parameter int unsigned PERIPH_ADDR_WIDTH = 4,
  parameter int unsigned REG_ADDR_WIDTH    = 8,
  parameter int unsigned CMD_DEPTH         = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic                                  hba_clk,
  input  logic                                  hba_reset,
  input  logic                                  app_cmd_valid,
  output logic                                  app_cmd_ready,
  input  logic [PERIPH_ADDR_WIDTH-1:0]          app_core_addr,
  input  logic [REG_ADDR_WIDTH-1:0]             app_reg_addr,
  input  logic [DBUS_WIDTH-1:0]                 app_data_in,
  input  logic                                  app_rnw,
  output logic                                  app_rsp_valid,
  output logic [DBUS_WIDTH-1:0]                 app_rsp_data,
  output logic                                  app_rsp_err,
  output logic                                  app_busy,
  output logic [$clog2(CMD_DEPTH):0]            app_fifo_count,
  input  logic                                  hba_mgrant,
  input  logic                                  hba_xferack,
  input  logic [DBUS_WIDTH-1:0]                 hba_dbus,
  output logic                                  master_request,
  output logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] master_abus,
  output logic                                  master_rnw,
  output logic                                  master_select,
  output logic [DBUS_WIDTH-1:0]                 master_dbus
);

  localparam int unsigned ADDR_WIDTH = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH;
  localparam int unsigned ENTRY_W    = 1 + ADDR_WIDTH + DBUS_WIDTH;
  localparam int unsigned RNW_BIT    = ENTRY_W - 1;
  localparam int unsigned WD_W       = wd_width(TIMEOUT_CYCLES);

  state_e                 r_state;
  logic                   r_wk_rnw;
  logic [ADDR_WIDTH-1:0]  r_wk_abus;
  logic [DBUS_WIDTH-1:0]  r_wk_data;
  logic [WD_W-1:0]        r_wd;

  logic [ENTRY_W-1:0]     w_entry_in;
  logic [ENTRY_W-1:0]     w_entry_out;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_wd_expire;

  // Entry layout {rnw, core, reg, data}
  assign w_entry_in    = {app_rnw, app_core_addr, app_reg_addr, app_data_in};
  assign w_pop         = (r_state == ST_IDLE) && !w_empty;
  assign app_cmd_ready = !w_full;
  assign app_busy      = !w_empty || (r_state != ST_IDLE);

  // Expiry fires on the last allowed XFER cycle, so select stays high TIMEOUT_CYCLES cycles
  assign w_wd_expire = (TIMEOUT_CYCLES != 0) &&
                       (({1'b0, r_wd} + (WD_W+1)'(1)) == (WD_W+1)'(TIMEOUT_CYCLES));

  hba_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .i_clk       (hba_clk),
    .i_rst       (hba_reset),
    .i_push      (app_cmd_valid),
    .i_push_data (w_entry_in),
    .i_pop       (w_pop),
    .o_pop_data  (w_entry_out),
    .o_count     (app_fifo_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Request/grant/transfer sequencing with registered bus and response outputs
  always_ff @(posedge hba_clk or posedge hba_reset) begin
    if (hba_reset) begin
      r_state        <= ST_IDLE;
      r_wk_rnw       <= 1'b0;
      r_wk_abus      <= '0;
      r_wk_data      <= '0;
      r_wd           <= '0;
      master_request <= 1'b0;
      master_abus    <= '0;
      master_rnw     <= 1'b0;
      master_select  <= 1'b0;
      master_dbus    <= '0;
      app_rsp_valid  <= 1'b0;
      app_rsp_data   <= '0;
      app_rsp_err    <= 1'b0;
    end else begin
      app_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_wk_rnw       <= w_entry_out[RNW_BIT];
            r_wk_abus      <= w_entry_out[DBUS_WIDTH +: ADDR_WIDTH];
            r_wk_data      <= w_entry_out[DBUS_WIDTH-1:0];
            master_request <= 1'b1;
            r_state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (hba_mgrant) begin
            master_request <= 1'b0;
            master_abus    <= r_wk_abus;
            master_rnw     <= r_wk_rnw;
            master_dbus    <= r_wk_rnw ? '0 : r_wk_data;
            master_select  <= 1'b1;
            r_wd           <= '0;
            r_state        <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (hba_xferack || w_wd_expire) begin
            app_rsp_valid <= 1'b1;
            app_rsp_err   <= !hba_xferack;
            app_rsp_data  <= (hba_xferack && r_wk_rnw) ? hba_dbus : '0;
            master_select <= 1'b0;
            master_abus   <= '0;
            master_rnw    <= 1'b0;
            master_dbus   <= '0;
            r_state       <= ST_IDLE;
          end else if (r_wd != {WD_W{1'b1}}) begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        default: begin
          master_request <= 1'b0;
          master_select  <= 1'b0;
          master_abus    <= '0;
          master_rnw     <= 1'b0;
          master_dbus    <= '0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hba_master_queued.sv
// Directed testbench for hba_master_queued (CMD_DEPTH=4, TIMEOUT_CYCLES=8).
module tb_hba_master_queued;

  logic        hba_clk = 1'b0;
  logic        hba_reset = 1'b1;
  logic        app_cmd_valid = 1'b0;
  logic        app_cmd_ready;
  logic [3:0]  app_core_addr = '0;
  logic [7:0]  app_reg_addr = '0;
  logic [7:0]  app_data_in = '0;
  logic        app_rnw = 1'b0;
  logic        app_rsp_valid;
  logic [7:0]  app_rsp_data;
  logic        app_rsp_err;
  logic        app_busy;
  logic [2:0]  app_fifo_count;
  logic        hba_mgrant = 1'b0;
  logic        hba_xferack = 1'b0;
  logic [7:0]  hba_dbus = '0;
  logic        master_request;
  logic [11:0] master_abus;
  logic        master_rnw;
  logic        master_select;
  logic [7:0]  master_dbus;

  int checks = 0;
  int errors = 0;

  hba_master_queued #(
    .DBUS_WIDTH        (8),
    .PERIPH_ADDR_WIDTH (4),
    .REG_ADDR_WIDTH    (8),
    .CMD_DEPTH         (4),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .hba_clk        (hba_clk),
    .hba_reset      (hba_reset),
    .app_cmd_valid  (app_cmd_valid),
    .app_cmd_ready  (app_cmd_ready),
    .app_core_addr  (app_core_addr),
    .app_reg_addr   (app_reg_addr),
    .app_data_in    (app_data_in),
    .app_rnw        (app_rnw),
    .app_rsp_valid  (app_rsp_valid),
    .app_rsp_data   (app_rsp_data),
    .app_rsp_err    (app_rsp_err),
    .app_busy       (app_busy),
    .app_fifo_count (app_fifo_count),
    .hba_mgrant     (hba_mgrant),
    .hba_xferack    (hba_xferack),
    .hba_dbus       (hba_dbus),
    .master_request (master_request),
    .master_abus    (master_abus),
    .master_rnw     (master_rnw),
    .master_select  (master_select),
    .master_dbus    (master_dbus)
  );

  always #5 hba_clk = ~hba_clk;

  // Hard stop in case the sequence hangs
  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hba_clk);
    #1;
  endtask

  task automatic set_cmd(input logic rnw, input logic [3:0] core, input logic [7:0] rg,
                         input logic [7:0] data);
    app_rnw       = rnw;
    app_core_addr = core;
    app_reg_addr  = rg;
    app_data_in   = data;
  endtask

  task automatic push(input logic rnw, input logic [3:0] core, input logic [7:0] rg,
                      input logic [7:0] data);
    set_cmd(rnw, core, rg, data);
    app_cmd_valid = 1'b1;
    tick();
    app_cmd_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!master_request && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_req"}, 32'(master_request), 32'd1);
  endtask

  // Full handshake with ack one cycle after select
  task automatic serve(input string tag, input logic [11:0] abus, input logic rnw,
                       input logic [7:0] wdata, input logic [7:0] rdata,
                       input logic [7:0] exp_rsp);
    wait_req(tag);
    hba_mgrant = 1'b1;
    tick();
    hba_mgrant = 1'b0;
    check({tag, "_sel"},  32'(master_select), 32'd1);
    check({tag, "_abus"}, 32'(master_abus),   32'(abus));
    check({tag, "_rnw"},  32'(master_rnw),    32'(rnw));
    check({tag, "_dbus"}, 32'(master_dbus),   32'(wdata));
    hba_dbus    = rdata;
    hba_xferack = 1'b1;
    tick();
    hba_xferack = 1'b0;
    hba_dbus    = '0;
    check({tag, "_rspv"}, 32'(app_rsp_valid), 32'd1);
    check({tag, "_rspd"}, 32'(app_rsp_data),  32'(exp_rsp));
    check({tag, "_rspe"}, 32'(app_rsp_err),   32'd0);
    check({tag, "_seloff"}, 32'(master_select), 32'd0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    hba_reset = 1'b0;
    check("rst_req",   32'(master_request), 32'd0);
    check("rst_sel",   32'(master_select),  32'd0);
    check("rst_abus",  32'(master_abus),    32'd0);
    check("rst_rspv",  32'(app_rsp_valid),  32'd0);
    check("rst_busy",  32'(app_busy),       32'd0);
    check("rst_count", 32'(app_fifo_count), 32'd0);
    check("rst_ready", 32'(app_cmd_ready),  32'd1);
    tick();

    // 1: write core 3 reg 0x10 data 0xA5, grant after 2 cycles, ack 1 cycle later
    push(1'b0, 4'h3, 8'h10, 8'hA5);
    check("t1_count1", 32'(app_fifo_count), 32'd1);
    check("t1_busy",   32'(app_busy),       32'd1);
    check("t1_noreq",  32'(master_request), 32'd0);
    tick();
    check("t1_req",    32'(master_request), 32'd1);
    check("t1_count0", 32'(app_fifo_count), 32'd0);
    tick();
    hba_mgrant = 1'b1;
    tick();
    hba_mgrant = 1'b0;
    check("t1_sel",    32'(master_select),  32'd1);
    check("t1_reqoff", 32'(master_request), 32'd0);
    check("t1_abus",   32'(master_abus),    32'h310);
    check("t1_dbus",   32'(master_dbus),    32'hA5);
    check("t1_rnw",    32'(master_rnw),     32'd0);
    hba_xferack = 1'b1;
    tick();
    hba_xferack = 1'b0;
    check("t1_rspv",   32'(app_rsp_valid),  32'd1);
    check("t1_rspd",   32'(app_rsp_data),   32'd0);
    check("t1_rspe",   32'(app_rsp_err),    32'd0);
    check("t1_abus0",  32'(master_abus),    32'd0);
    check("t1_dbus0",  32'(master_dbus),    32'd0);
    tick();
    check("t1_rspv1c", 32'(app_rsp_valid),  32'd0);
    check("t1_idle",   32'(app_busy),       32'd0);

    // 2: read core 1 reg 0x02, slave returns 0x5C
    push(1'b1, 4'h1, 8'h02, 8'hFF);
    tick();
    check("t2_reqdbus", 32'(master_dbus), 32'd0);
    serve("t2", 12'h102, 1'b1, 8'h00, 8'h5C, 8'h5C);

    // 3: grant held off; first command parks in REQ, four more fill the FIFO
    for (int i = 0; i < 5; i++) begin
      set_cmd(1'b1, 4'(i), 8'(8'h20 + i), 8'h00);
      app_cmd_valid = 1'b1;
      tick();
    end
    check("t3_full_count", 32'(app_fifo_count), 32'd4);
    check("t3_full_ready", 32'(app_cmd_ready),  32'd0);
    set_cmd(1'b1, 4'd5, 8'h25, 8'h00);
    tick();
    tick();
    check("t3_held_count", 32'(app_fifo_count), 32'd4);
    check("t3_held_req",   32'(master_request), 32'd1);
    serve("t3_c0", 12'h020, 1'b1, 8'h00, 8'h40, 8'h40);
    check("t3_still_full", 32'(app_cmd_ready),  32'd0);
    tick();
    check("t3_pop_count",  32'(app_fifo_count), 32'd3);
    check("t3_pop_ready",  32'(app_cmd_ready),  32'd1);
    tick();
    app_cmd_valid = 1'b0;
    check("t3_push5_count", 32'(app_fifo_count), 32'd4);
    for (int i = 1; i < 6; i++) begin
      serve($sformatf("t3_c%0d", i), {4'(i), 8'(8'h20 + i)}, 1'b1, 8'h00,
            8'(8'h40 + i), 8'(8'h40 + i));
    end
    tick();
    check("t3_drained", 32'(app_busy), 32'd0);

    // 4: no ack -> timeout 8 cycles after select, then next command proceeds
    push(1'b0, 4'h2, 8'h33, 8'h11);
    push(1'b0, 4'h5, 8'h44, 8'h22);
    wait_req("t4");
    hba_mgrant = 1'b1;
    tick();
    hba_mgrant = 1'b0;
    check("t4_sel", 32'(master_select), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t4_rspv_k%0d", k), 32'(app_rsp_valid), 32'(k == 8));
      check($sformatf("t4_sel_k%0d", k),  32'(master_select), 32'(k < 8));
    end
    check("t4_err",  32'(app_rsp_err),  32'd1);
    check("t4_data", 32'(app_rsp_data), 32'd0);
    tick();
    check("t4_rspv_off", 32'(app_rsp_valid), 32'd0);
    serve("t4_next", 12'h544, 1'b0, 8'h22, 8'h00, 8'h00);

    // 5: ack on the expiry cycle wins
    push(1'b1, 4'h7, 8'h55, 8'h00);
    wait_req("t5");
    hba_mgrant = 1'b1;
    tick();
    hba_mgrant = 1'b0;
    repeat (7) tick();
    check("t5_sel_hold", 32'(master_select), 32'd1);
    check("t5_no_rsp",   32'(app_rsp_valid), 32'd0);
    hba_dbus    = 8'h9E;
    hba_xferack = 1'b1;
    tick();
    hba_xferack = 1'b0;
    hba_dbus    = '0;
    check("t5_rspv", 32'(app_rsp_valid), 32'd1);
    check("t5_err",  32'(app_rsp_err),   32'd0);
    check("t5_data", 32'(app_rsp_data),  32'h9E);

    // 6: reset mid-XFER with two entries queued
    tick();
    push(1'b0, 4'h8, 8'h01, 8'h01);
    push(1'b0, 4'h8, 8'h02, 8'h02);
    push(1'b0, 4'h8, 8'h03, 8'h03);
    wait_req("t6");
    hba_mgrant = 1'b1;
    tick();
    hba_mgrant = 1'b0;
    check("t6_sel",   32'(master_select),  32'd1);
    check("t6_count", 32'(app_fifo_count), 32'd2);
    hba_reset = 1'b1;
    #1;
    check("t6_rst_sel",   32'(master_select),  32'd0);
    check("t6_rst_abus",  32'(master_abus),    32'd0);
    check("t6_rst_dbus",  32'(master_dbus),    32'd0);
    check("t6_rst_count", 32'(app_fifo_count), 32'd0);
    check("t6_rst_busy",  32'(app_busy),       32'd0);
    check("t6_rst_ready", 32'(app_cmd_ready),  32'd1);
    tick();
    tick();
    hba_reset = 1'b0;
    check("t6_rst_rspv", 32'(app_rsp_valid), 32'd0);
    tick();
    check("t6_post_rspv", 32'(app_rsp_valid), 32'd0);
    check("t6_post_req",  32'(master_request), 32'd0);
    push(1'b0, 4'h9, 8'h66, 8'h77);
    serve("t6_new", 12'h966, 1'b0, 8'h77, 8'h00, 8'h00);
    tick();
    check("t6_idle", 32'(app_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
